// File: rtl/uart_tx_feeder_pkg.sv
// -----------------------------------------------------------------------------
// uart_tx_feeder_pkg
// Shared constants and types for the UART loopback path (uart_rx -> feeder ->
// uart_tx).
//   UART_DATA_W     : width of one UART data byte
//   CLOCK_FREQUENCY : default system clock, shared with uart_rx/uart_tx
//   BAUD_RATE       : default line rate, shared with uart_rx/uart_tx
//   feeder_state_t  : launch FSM encoding (IDLE, LAUNCH, BUSY, GAP)
// -----------------------------------------------------------------------------
package uart_tx_feeder_pkg;

    localparam int UART_DATA_W     = 8;
    localparam int CLOCK_FREQUENCY = 100_000_000;
    localparam int BAUD_RATE       = 9600;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        BUSY   = 2'd2,
        GAP    = 2'd3
    } feeder_state_t;

endpackage

// File: rtl/uart_tx_feeder_if.sv
// -----------------------------------------------------------------------------
// uart_tx_feeder_if
// Bundles the feeder's byte-write side, uart_tx handshake and status outputs.
// Directions are named from the feeder's point of view (i_ = into feeder).
//   master : the feeder itself
//   slave  : the surrounding logic (uart_rx, uart_tx, control/status)
// Signals:
//   i_wr_dv/i_wr_byte      : one-cycle byte write strobe and data
//   i_tx_active/i_tx_done  : status from uart_tx
//   i_clr_ovf              : clears the sticky overflow flag
//   o_tx_dv/o_tx_byte      : launch strobe and byte to uart_tx
//   o_count/o_empty/o_full : FIFO occupancy
//   o_overflow             : sticky dropped-write flag
// -----------------------------------------------------------------------------
interface uart_tx_feeder_if #(
    parameter int DEPTH = 16
) ();
    import uart_tx_feeder_pkg::*;

    localparam int ADDR_W = $clog2(DEPTH);

    logic                   i_wr_dv;
    logic [UART_DATA_W-1:0] i_wr_byte;
    logic                   i_tx_active;
    logic                   i_tx_done;
    logic                   i_clr_ovf;
    logic                   o_tx_dv;
    logic [UART_DATA_W-1:0] o_tx_byte;
    logic [ADDR_W:0]        o_count;
    logic                   o_empty;
    logic                   o_full;
    logic                   o_overflow;

    modport master (
        input  i_wr_dv, i_wr_byte, i_tx_active, i_tx_done, i_clr_ovf,
        output o_tx_dv, o_tx_byte, o_count, o_empty, o_full, o_overflow
    );

    modport slave (
        output i_wr_dv, i_wr_byte, i_tx_active, i_tx_done, i_clr_ovf,
        input  o_tx_dv, o_tx_byte, o_count, o_empty, o_full, o_overflow
    );

endinterface

// File: rtl/uart_tx_feeder_fifo.sv
// -----------------------------------------------------------------------------
// uart_sync_fifo
// Single-clock circular byte FIFO with a separate occupancy counter and a
// sticky overflow flag.
//   i_clk, i_rstn          : clock, async active-low reset
//   i_push, i_push_data    : write request and data
//   i_pop                  : read request (head advances)
//   i_clr_ovf              : clears o_overflow (a same-cycle drop wins)
//   o_pop_data             : current head entry
//   o_count                : occupancy 0..DEPTH
//   o_empty, o_full        : occupancy flags
//   o_overflow             : sticky, set when a write is dropped
// -----------------------------------------------------------------------------
module uart_sync_fifo
    import uart_tx_feeder_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DATA_W = UART_DATA_W
) (
    input  logic                      i_clk,
    input  logic                      i_rstn,
    input  logic                      i_push,
    input  logic [DATA_W-1:0]         i_push_data,
    input  logic                      i_pop,
    input  logic                      i_clr_ovf,
    output logic [DATA_W-1:0]         o_pop_data,
    output logic [$clog2(DEPTH):0]    o_count,
    output logic                      o_empty,
    output logic                      o_full,
    output logic                      o_overflow
);

    localparam int              ADDR_W     = $clog2(DEPTH);
    localparam logic [ADDR_W:0] FULL_COUNT = DEPTH[ADDR_W:0];

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_overflow;

    logic w_full;
    logic w_empty;
    logic w_do_pop;
    logic w_do_push;
    logic w_drop;

    assign w_full    = (r_count == FULL_COUNT);
    assign w_empty   = (r_count == '0);
    assign w_do_pop  = i_pop && !w_empty;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign w_do_push = i_push && (!w_full || w_do_pop);
    assign w_drop    = i_push && !w_do_push;

    // Storage is never read before it is written, so it carries no reset.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (i_clr_ovf) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign o_pop_data = r_mem[r_rd_ptr];
    assign o_count    = r_count;
    assign o_empty    = w_empty;
    assign o_full     = w_full;
    assign o_overflow = r_overflow;

endmodule

// File: rtl/uart_tx_feeder.sv
// -----------------------------------------------------------------------------
// uart_tx_feeder
// Buffers single-cycle byte strobes and replays them to uart_tx one frame at a
// time, relaunching a byte if uart_tx never reports it active.
//   i_clk, i_rstn : clock, async active-low reset
//   bus (master)  : write strobe, uart_tx handshake, FIFO status
//                   (see uart_tx_feeder_if)
// -----------------------------------------------------------------------------
module uart_tx_feeder
    import uart_tx_feeder_pkg::*;
#(
    parameter int DEPTH          = 16,
    parameter int ACTIVE_TIMEOUT = 16
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    uart_tx_feeder_if.master   bus
);

    localparam int               ADDR_W   = $clog2(DEPTH);
    localparam int               TMR_W    = $clog2(ACTIVE_TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACTIVE_TIMEOUT - 1);

    feeder_state_t          r_state;
    feeder_state_t          w_next_state;
    logic                   r_tx_dv;
    logic [UART_DATA_W-1:0] r_tx_byte;
    logic [TMR_W-1:0]       r_timer;

    logic                   w_pop;
    logic                   w_timeout;
    logic [UART_DATA_W-1:0] w_head;
    logic [ADDR_W:0]        w_count;
    logic                   w_empty;
    logic                   w_full;
    logic                   w_overflow;

    uart_sync_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (UART_DATA_W)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_rstn      (i_rstn),
        .i_push      (bus.i_wr_dv),
        .i_push_data (bus.i_wr_byte),
        .i_pop       (w_pop),
        .i_clr_ovf   (bus.i_clr_ovf),
        .o_pop_data  (w_head),
        .o_count     (w_count),
        .o_empty     (w_empty),
        .o_full      (w_full),
        .o_overflow  (w_overflow)
    );

    // State register.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state: tx_done only matters in BUSY; GAP lets uart_tx drop active.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (!w_empty && !bus.i_tx_active) w_next_state = LAUNCH;
            LAUNCH:  if (bus.i_tx_active)              w_next_state = BUSY;
            BUSY:    if (bus.i_tx_done)                w_next_state = GAP;
            GAP:                                       w_next_state = IDLE;
            default:                                   w_next_state = IDLE;
        endcase
    end

    // Control: pop only from IDLE; relaunch once the wait for active expires.
    always_comb begin
        w_pop     = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            IDLE:    w_pop     = !w_empty && !bus.i_tx_active;
            LAUNCH:  w_timeout = !bus.i_tx_active && (r_timer == TMR_LAST);
            default: ;
        endcase
    end

    // Registered launch strobe, held byte and the active-wait timer.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_tx_dv   <= 1'b0;
            r_tx_byte <= '0;
            r_timer   <= '0;
        end else begin
            r_tx_dv <= w_pop || w_timeout;
            if (w_pop) begin
                r_tx_byte <= w_head;
            end
            if (r_state == LAUNCH && !bus.i_tx_active && !w_timeout) begin
                r_timer <= r_timer + 1'b1;
            end else begin
                r_timer <= '0;
            end
        end
    end

    assign bus.o_tx_dv    = r_tx_dv;
    assign bus.o_tx_byte  = r_tx_byte;
    assign bus.o_count    = w_count;
    assign bus.o_empty    = w_empty;
    assign bus.o_full     = w_full;
    assign bus.o_overflow = w_overflow;

endmodule
